// File: rtl/cpu_ctrl.sv
// cpu_ctrl: two-byte fetch/execute sequencer driving PC, register file, RAM and ALU strobes.
// Every instruction takes exactly four cycles (FA, FB, EA, EB); outputs decode from state and the instruction register.
module cpu_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       halt,
    output logic       waits,
    output logic       fetcha,
    output logic       fetchb,
    output logic       execa,
    output logic       execb,
    input  logic [7:0] pc_q,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [7:0] pc_din,
    input  logic [7:0] ram_q,
    output logic [7:0] ram_addr,
    output logic       ram_rden,
    output logic       ram_wren,
    output logic [7:0] ram_din,
    output logic [3:0] asel,
    output logic [3:0] bsel,
    output logic [3:0] csel,
    input  logic [7:0] reg_aout,
    output logic       cload,
    output logic [7:0] cin,
    output logic       alu_ena,
    output logic [1:0] alu_ctrl,
    input  logic [7:0] alu_sout,
    input  logic       cflag,
    input  logic       zflag,
    output logic       illegal
);
    localparam logic [2:0] S_WAIT = 3'd0;
    localparam logic [2:0] S_FA   = 3'd1;
    localparam logic [2:0] S_FB   = 3'd2;
    localparam logic [2:0] S_EA   = 3'd3;
    localparam logic [2:0] S_EB   = 3'd4;

    logic [2:0] state_q, state_d;
    logic [7:0] ir_q, ir_d, opr_q, opr_d;
    logic       halt_pend_q, halt_pend_d;

    logic [2:0] f;
    logic [1:0] s;
    logic [3:0] t;
    logic       is_ld, is_st, is_li, is_alu, is_hlt, is_bad, jmp_taken;
    logic       ld_rd_ea, alu_ea;

    assign f = ir_q[7:5];
    assign s = ir_q[4:3];
    assign t = {1'b0, ir_q[2:0]};

    assign is_ld     = (f == 3'd0) && (s == 2'd1);
    assign is_st     = (f == 3'd0) && (s == 2'd2);
    assign is_li     = (f == 3'd0) && (s == 2'd3);
    assign is_alu    = (f == 3'd4);
    assign is_hlt    = (f == 3'd7) && (s == 2'd3);
    assign is_bad    = (f inside {3'd1, 3'd2, 3'd3, 3'd5}) || ((f == 3'd7) && (s != 2'd3));
    // Flags are the registered ones left by the last ALU instruction.
    assign jmp_taken = (f == 3'd6) && ((s == 2'd0) || ((s == 2'd1) && zflag) || ((s == 2'd2) && cflag));

    assign waits  = (state_q == S_WAIT);
    assign fetcha = (state_q == S_FA);
    assign fetchb = (state_q == S_FB);
    assign execa  = (state_q == S_EA);
    assign execb  = (state_q == S_EB);

    always_comb begin
        state_d     = waits  ? (run ? S_FA : S_WAIT) :
                      fetcha ? S_FB :
                      fetchb ? S_EA :
                      execa  ? S_EB :
                      execb  ? ((is_hlt || halt_pend_q || halt) ? S_WAIT : S_FA) : S_WAIT;
        halt_pend_d = (state_d == S_WAIT) ? 1'b0 : (halt_pend_q || (halt && !waits));
        ir_d        = fetchb ? ram_q : ir_q;
        opr_d       = execa ? ram_q : opr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WAIT;
            ir_q        <= 8'h00;
            opr_q       <= 8'h00;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            opr_q       <= opr_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // In EA the operand is still on ram_q, so LD addressing and ALU B-select use it directly.
    assign ld_rd_ea = execa && is_ld;
    assign alu_ea   = execa && is_alu;

    assign pc_inc   = fetcha || fetchb;
    assign pc_load  = execb && jmp_taken;
    assign pc_din   = pc_load ? opr_q : 8'h00;

    assign ram_rden = fetcha || fetchb || ld_rd_ea;
    assign ram_wren = execb && is_st;
    assign ram_addr = (fetcha || fetchb) ? pc_q : ld_rd_ea ? ram_q : ram_wren ? opr_q : 8'h00;
    assign ram_din  = ram_wren ? reg_aout : 8'h00;

    assign alu_ena  = alu_ea;
    assign alu_ctrl = alu_ea ? s : 2'd0;
    assign asel     = (alu_ea || ram_wren) ? t : 4'd0;
    assign bsel     = alu_ea ? {1'b0, ram_q[2:0]} : 4'd0;

    assign cload    = execb && (is_ld || is_li || is_alu);
    assign csel     = cload ? t : 4'd0;
    assign cin      = !cload ? 8'h00 : is_ld ? ram_q : is_li ? opr_q : alu_sout;

    assign illegal  = execb && is_bad;
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: drives cpu_ctrl inside a behavioural PC/RAM/regfile/ALU environment against an ISA-level reference model.
module tb_cpu_ctrl;
    logic clk = 1'b0, rst = 1'b1, run = 1'b0, halt = 1'b0;
    logic waits, fetcha, fetchb, execa, execb, pc_inc, pc_load, ram_rden, ram_wren, cload, alu_ena, illegal;
    logic [7:0] pc_din, ram_addr, ram_din, cin;
    logic [3:0] asel, bsel, csel;
    logic [1:0] alu_ctrl;
    logic [7:0] pc_q, ram_q, reg_aout, alu_sout;
    logic       cflag, zflag;

    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic [7:0] rf [16];
    logic [7:0] rimg [16];
    logic       load = 1'b0;
    logic [7:0] start_pc = 8'h00;

    logic [7:0]  mm [256];
    logic [7:0]  mr [16];
    logic [7:0]  mpc;
    logic        mz, mc;
    logic [39:0] exp_q [$];
    int checks = 0, failures = 0;

    cpu_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt),
        .waits(waits), .fetcha(fetcha), .fetchb(fetchb), .execa(execa), .execb(execb),
        .pc_q(pc_q), .pc_inc(pc_inc), .pc_load(pc_load), .pc_din(pc_din),
        .ram_q(ram_q), .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_din(ram_din),
        .asel(asel), .bsel(bsel), .csel(csel), .reg_aout(reg_aout),
        .cload(cload), .cin(cin), .alu_ena(alu_ena), .alu_ctrl(alu_ctrl), .alu_sout(alu_sout),
        .cflag(cflag), .zflag(zflag), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // ALU semantics shared by the environment ALU and the model: {carry, zero, result}.
    function automatic logic [9:0] alu_f(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (c)
            2'd0:    r = {1'b0, a} + {1'b0, b};
            2'd1:    r = {1'b0, a} - {1'b0, b};
            2'd2:    r = {1'b0, a & b};
            default: r = {1'b0, a ^ b};
        endcase
        return {r[8], r[7:0] == 8'h00, r[7:0]};
    endfunction

    assign reg_aout = rf[asel];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= 8'h00; ram_q <= 8'h00; alu_sout <= 8'h00; cflag <= 1'b0; zflag <= 1'b0;
        end else if (load) begin
            mem <= img; rf <= rimg; pc_q <= start_pc; cflag <= 1'b0; zflag <= 1'b0;
        end else begin
            if (pc_load) pc_q <= pc_din;
            else if (pc_inc) pc_q <= pc_q + 8'd1;
            if (ram_wren) mem[ram_addr] <= ram_din;
            if (ram_rden) ram_q <= mem[ram_addr];
            if (cload) rf[csel] <= cin;
            if (alu_ena) {cflag, zflag, alu_sout} <= alu_f(alu_ctrl, rf[asel], rf[bsel]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: protocol rules every cycle, scoreboard pop on every EB.
    always @(negedge clk) begin
        logic [39:0] e, a;
        if (!rst) begin
            checks++;
            if ((32'(waits) + 32'(fetcha) + 32'(fetchb) + 32'(execa) + 32'(execb)) != 1 || (ram_rden && ram_wren) ||
                (pc_inc && pc_load) || (!execb && (cload || ram_wren || pc_load || illegal))) begin
                failures++;
                $display("FAIL proto: state=%b%b%b%b%b rden=%b wren=%b inc=%b load=%b cload=%b ill=%b",
                         waits, fetcha, fetchb, execa, execb, ram_rden, ram_wren, pc_inc, pc_load, cload, illegal);
            end
            if (execb) begin
                a = {cload, cload ? csel : 4'd0, cload ? cin : 8'd0, ram_wren, ram_wren ? ram_addr : 8'd0,
                     ram_wren ? ram_din : 8'd0, pc_load, pc_load ? pc_din : 8'd0, illegal};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL eb_unexpected: got %h expected none", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display("FAIL eb_effects: got %h expected %h", a, e);
                    end
                end
            end
        end
    end

    task automatic model_run(input int maxn, output int n);
        logic [7:0] op, o, eci, ead, edi, epd;
        logic [3:0] t, ecs;
        logic [2:0] f;
        logic [1:0] s;
        logic [9:0] r;
        logic done, ecl, ewr, epl, eil;
        n = 0;
        done = 1'b0;
        while (!done && n < maxn) begin
            op = mm[mpc]; o = mm[mpc + 8'd1]; mpc = mpc + 8'd2;
            f = op[7:5]; s = op[4:3]; t = {1'b0, op[2:0]};
            {ecl, ecs, eci, ewr, ead, edi, epl, epd, eil} = '0;
            n++;
            if (f == 3'd0 && s == 2'd1) begin
                ecl = 1'b1; ecs = t; eci = mm[o]; mr[t] = mm[o];
            end else if (f == 3'd0 && s == 2'd2) begin
                ewr = 1'b1; ead = o; edi = mr[t]; mm[o] = mr[t];
            end else if (f == 3'd0 && s == 2'd3) begin
                ecl = 1'b1; ecs = t; eci = o; mr[t] = o;
            end else if (f == 3'd4) begin
                r = alu_f(s, mr[t], mr[{1'b0, o[2:0]}]);
                ecl = 1'b1; ecs = t; eci = r[7:0]; mr[t] = r[7:0]; mc = r[9]; mz = r[8];
            end else if (f == 3'd6) begin
                epl = (s == 2'd0) || (s == 2'd1 && mz) || (s == 2'd2 && mc);
                if (epl) begin epd = o; mpc = o; end
            end else if (f == 3'd7 && s == 2'd3) begin
                done = 1'b1;
            end else if (f != 3'd0) begin
                eil = 1'b1;
            end
            exp_q.push_back({ecl, ecs, eci, ewr, ead, edi, epl, epd, eil});
        end
    endtask

    task automatic load_prog(input logic [7:0] sp);
        for (int i = 0; i < 256; i++) mm[i] = img[i];
        for (int i = 0; i < 16; i++) mr[i] = rimg[i];
        mz = 1'b0; mc = 1'b0; mpc = sp; start_pc = sp;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) rimg[i] = 8'($urandom);
    endtask

    task automatic run_prog(input string name, input int maxn, input int halt_at, input bit hw);
        int n, c, bad;
        model_run(maxn, n);
        if (hw) begin
            halt = 1'b1;
            repeat (3) @(negedge clk);
        end
        run = 1'b1; halt = 1'b0;
        @(negedge clk);
        run = 1'b0;
        c = 0;
        while (!waits && c < 2000) begin
            c++;
            halt = (c == halt_at);
            @(negedge clk);
        end
        halt = 1'b0;
        chk({name, "_cycles"}, 64'(c), 64'(4 * n));
        if (!waits) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk({name, "_pc"}, 64'(pc_q), 64'(mpc));
        bad = 0;
        for (int i = 0; i < 16; i++) if (rf[i] !== mr[i]) bad++;
        chk({name, "_regs"}, 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) bad++;
        chk({name, "_mem"}, 64'(bad), 64'd0);
    endtask

    task automatic gen_prog();
        int k, r, q;
        logic [7:0] op, o;
        logic [2:0] t3, fi;
        logic [1:0] s2;
        fill_random();
        k = $urandom_range(6, 30);
        for (int i = 0; i < k; i++) begin
            r = $urandom_range(0, 15); t3 = 3'($urandom); s2 = 2'($urandom); o = 8'($urandom);
            case (r)
                0, 1, 2, 14, 15: op = {5'b00011, t3};
                3, 4:            op = {5'b00001, t3};
                5, 6:            begin op = {5'b00010, t3}; o = {1'b1, o[6:0]}; end
                7, 8, 9, 10:     op = {3'b100, s2, t3};
                11:              begin op = {3'b110, s2, t3}; o = 8'(2 * $urandom_range(i + 1, k)); end
                12: begin
                    q = $urandom_range(0, 4);
                    fi = q == 0 ? 3'd1 : q == 1 ? 3'd2 : q == 2 ? 3'd3 : q == 3 ? 3'd5 : 3'd7;
                    if (fi == 3'd7) s2 = 2'($urandom_range(0, 2));
                    op = {fi, s2, t3};
                end
                default:         op = $urandom_range(0, 1) ? {5'b00000, t3} : {5'b11011, t3};
            endcase
            img[2 * i] = op;
            img[2 * i + 1] = o;
        end
        img[2 * k] = 8'hFF;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_waits"}, 64'(waits), 64'd1);
        chk({name, "_outs"}, 64'({fetcha, fetchb, execa, execb, pc_inc, pc_load, pc_din, ram_addr, ram_rden, ram_wren,
                                  ram_din, asel, bsel, csel, cload, cin, alu_ena, alu_ctrl, illegal}), 64'd0);
    endtask

    initial begin
        int c;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_held");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_released");

        fill_random();
        img[0] = 8'h19; img[1] = 8'h05; img[2] = 8'hFF;
        load_prog(8'h00);
        run_prog("li", 100, 0, 1'b0);

        fill_random();
        img[0] = 8'h19; img[1] = 8'h0F; img[2] = 8'h1A; img[3] = 8'h01;
        img[4] = 8'h81; img[5] = 8'h02; img[6] = 8'hC8; img[7] = 8'h40; img[8] = 8'hFF;
        load_prog(8'h00);
        run_prog("alu_jz", 100, 0, 1'b0);

        fill_random();
        img[0] = 8'h0B; img[1] = 8'h80; img[2] = 8'h13; img[3] = 8'h81;
        img[4] = 8'h28; img[5] = 8'h00; img[6] = 8'hFF; img[8'h80] = 8'hA5;
        load_prog(8'h00);
        run_prog("ld_st_ill", 100, 0, 1'b0);

        fill_random();
        img[0] = 8'h19; img[1] = 8'h11; img[2] = 8'h1A; img[3] = 8'h22;
        img[4] = 8'h1B; img[5] = 8'h33; img[6] = 8'hFF;
        load_prog(8'h00);
        run_prog("halt_fb", 2, 6, 1'b0);
        run_prog("resume", 100, 0, 1'b0);

        fill_random();
        img[8'hFF] = 8'h1A; img[0] = 8'h3C; img[1] = 8'hFF;
        load_prog(8'hFF);
        run_prog("wrap", 100, 0, 1'b0);

        for (int p = 0; p < 20; p++) begin
            gen_prog();
            load_prog(8'h00);
            run_prog($sformatf("rand%0d", p), 1000, 0, 1'($urandom_range(0, 1)));
        end

        fill_random();
        img[0] = 8'h13; img[1] = 8'h90; img[2] = 8'hFF; img[8'h90] = 8'h11; rimg[3] = 8'h77;
        load_prog(8'h00);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        c = 0;
        while (!execa && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("reach_ea", 64'(execa), 64'd1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_async");
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_wren", 64'(ram_wren), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("st_aborted", 64'(mem[8'h90]), 64'h11);
        chk_reset_outputs("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
